// File: rtl/cam_mux_rr_arbiter_if.sv
// Handshake and bus bundle for the CAM read-mux round-robin arbiter.
// The arbiter side uses modport master; the requester/consumer side uses slave.
interface cam_mux_rr_arbiter_if #(
    parameter int NUM_REQ = 32,
    parameter int SEL_W   = 5,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]             req_i;
    logic [NUM_REQ-1:0][DATA_W-1:0] data_i;
    logic [SEL_W-1:0]               sel_o;
    logic [DATA_W-1:0]              data_o;
    logic                           valid_o;
    logic                           ready_i;
    logic [NUM_REQ-1:0]             gnt_o;
    logic                           busy_o;

    modport master (
        input  req_i, data_i, ready_i,
        output sel_o, data_o, valid_o, gnt_o, busy_o
    );

    modport slave (
        output req_i, data_i, ready_i,
        input  sel_o, data_o, valid_o, gnt_o, busy_o
    );
endinterface

// File: rtl/cam_mux_rr_arbiter.sv
// Round-robin arbiter sharing the 32-way, 32-bit read mux among 32 requesters.
// The selected word is offered downstream with a valid/ready handshake.
// Optional feature macro: ARB_BACK_TO_BACK_EN -- when defined, a handshake
// immediately re-arbitrates among the remaining requesters and stays in SERVE,
// giving one transfer per cycle; when undefined the arbiter always returns to
// IDLE after a handshake.
module cam_mux_rr_arbiter #(
    parameter int NUM_REQ = 32,
    parameter int SEL_W   = 5,
    parameter int DATA_W  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    cam_mux_rr_arbiter_if.master  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_e;

    state_e           state_q;
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] sel_q;

    logic             serve_w;
    logic             hs_w;
    logic [SEL_W-1:0] idle_pick_w;
    logic [SEL_W-1:0] next_ptr_w;

    // Circular priority search: the first set bit at or after 'start',
    // wrapping modulo NUM_REQ. The request vector is rotated so that 'start'
    // lands on bit 0, the lowest set bit is found, and the offset is added back.
    function automatic logic [SEL_W-1:0] rr_search(
        input logic [NUM_REQ-1:0] req,
        input logic [SEL_W-1:0]   start
    );
        logic [2*NUM_REQ-1:0] dbl;
        logic [NUM_REQ-1:0]   rot;
        logic [SEL_W-1:0]     off;
        dbl = {req, req} >> start;
        rot = dbl[NUM_REQ-1:0];
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = SEL_W'(i);
        end
        return start + off;
    endfunction

    assign serve_w     = (state_q == SERVE);
    assign hs_w        = serve_w & bus.ready_i;
    assign idle_pick_w = rr_search(bus.req_i, ptr_q);
    assign next_ptr_w  = sel_q + SEL_W'(1);

`ifdef ARB_BACK_TO_BACK_EN
    logic [NUM_REQ-1:0] remain_w;
    logic [SEL_W-1:0]   b2b_pick_w;

    // Requests still pending once the current winner is served.
    assign remain_w   = bus.req_i & ~(NUM_REQ'(1) << sel_q);
    assign b2b_pick_w = rr_search(remain_w, next_ptr_w);
`endif

    // Arbitration FSM: state, rotating priority pointer and registered select.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|bus.req_i) begin
                        sel_q   <= idle_pick_w;
                        state_q <= SERVE;
                    end
                end
                SERVE: begin
                    if (hs_w) begin
                        // A handshake wins over a same-cycle request drop.
                        ptr_q <= next_ptr_w;
`ifdef ARB_BACK_TO_BACK_EN
                        if (|remain_w) begin
                            sel_q <= b2b_pick_w;
                        end else begin
                            state_q <= IDLE;
                        end
`else
                        state_q <= IDLE;
`endif
                    end else if (!bus.req_i[sel_q]) begin
                        // Requester withdrew before being accepted: abort
                        // without a grant and keep the pointer where it was.
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Downstream outputs: select and valid come straight from registers,
    // the data path runs through the mux and is zeroed when not valid.
    always_comb begin
        bus.sel_o   = sel_q;
        bus.valid_o = serve_w;
        bus.busy_o  = serve_w;
        bus.data_o  = serve_w ? bus.data_i[sel_q] : '0;
    end

    // One-hot grant, asserted only in the handshake cycle.
    always_comb begin
        bus.gnt_o        = '0;
        bus.gnt_o[sel_q] = hs_w;
    end

endmodule

// File: tb/tb_cam_mux_rr_arbiter.sv
// Self-checking bench for cam_mux_rr_arbiter: directed scenarios followed by
// randomized traffic, all checked against a behavioural reference model.
// Honours ARB_BACK_TO_BACK_EN the same way as the design.
module tb_cam_mux_rr_arbiter;

    logic clk;
    logic rst_n;

    cam_mux_rr_arbiter_if bus ();

    cam_mux_rr_arbiter dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Reference model state: whether a word is being offered, which
    // requester is offered, and where the next search starts.
    bit m_serving;
    int m_sel;
    int m_ptr;

    logic [31:0] obs_gnt;
    logic [31:0] obs_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int rr_find(input logic [31:0] r, input int start);
        for (int k = 0; k < 32; k++) begin
            int idx;
            idx = (start + k) % 32;
            if (r[idx]) return idx;
        end
        return start;
    endfunction

    // Advance the reference model by one clock edge using the inputs that
    // were present before the edge.
    task automatic model_step();
        logic [31:0] r;
        bit hs;
        r  = bus.req_i;
        hs = m_serving && bus.ready_i;
        if (!m_serving) begin
            if (r != 0) begin
                m_sel     = rr_find(r, m_ptr);
                m_serving = 1;
            end
        end else if (hs) begin
            m_ptr = (m_sel + 1) % 32;
`ifdef ARB_BACK_TO_BACK_EN
            r[m_sel] = 1'b0;
            if (r != 0) m_sel = rr_find(r, m_ptr);
            else        m_serving = 0;
`else
            m_serving = 0;
`endif
        end else if (!r[m_sel]) begin
            m_serving = 0;
        end
    endtask

    task automatic model_reset();
        m_serving = 0;
        m_sel     = 0;
        m_ptr     = 0;
    endtask

    // One clock cycle: drive inputs after the falling edge, compare all
    // outputs against the model, then let the model follow the rising edge.
    task automatic do_cycle(input logic [31:0] req, input logic rdy, input bit rand_data);
        logic [31:0] exp_gnt;
        @(negedge clk);
        bus.req_i   = req;
        bus.ready_i = rdy;
        if (rand_data) begin
            for (int i = 0; i < 32; i++) bus.data_i[i] = $urandom;
        end
        #1;
        exp_gnt = 0;
        if (m_serving && rdy) exp_gnt[m_sel] = 1'b1;
        obs_gnt  = bus.gnt_o;
        obs_data = bus.data_o;
        check("valid", {31'd0, bus.valid_o}, {31'd0, m_serving});
        check("busy",  {31'd0, bus.busy_o},  {31'd0, m_serving});
        check("sel",   {27'd0, bus.sel_o},   32'(m_sel));
        check("data",  bus.data_o, m_serving ? bus.data_i[m_sel] : 32'd0);
        check("gnt",   bus.gnt_o,  exp_gnt);
        $display("cyc req=%08h rdy=%0d -> valid=%0d sel=%0d gnt=%08h data=%08h",
                 req, rdy, bus.valid_o, bus.sel_o, bus.gnt_o, bus.data_o);
        @(posedge clk);
        model_step();
    endtask

    task automatic go_idle();
        do_cycle(32'd0, 1'b1, 1'b1);
        do_cycle(32'd0, 1'b1, 1'b1);
    endtask

    logic [31:0] cur_req;
    logic [31:0] ptr_probe;

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        bus.req_i   = 32'hFFFF_FFFF;
        bus.ready_i = 1'b1;
        for (int i = 0; i < 32; i++) bus.data_i[i] = $urandom;
        rst_n = 1'b0;

        // Reset held with every requester active: nothing must be offered.
        repeat (2) begin
            @(negedge clk);
            #1;
            check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
            check("rst_gnt",   bus.gnt_o,  32'd0);
            check("rst_data",  bus.data_o, 32'd0);
            check("rst_busy",  {31'd0, bus.busy_o}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_step();
        // First grant after release must go to requester 0.
        do_cycle(32'hFFFF_FFFF, 1'b1, 1'b1);
        check("first_sel", obs_gnt, 32'h0000_0001);
        go_idle();

        // Requesters 0 and 31 alternating under constant ready.
        for (int i = 0; i < 8; i++) do_cycle(32'h8000_0001, 1'b1, 1'b1);
        go_idle();

        // Lone requester 31 with a known word, then pointer wrap to 0.
        bus.data_i[31] = 32'hDEAD_BEEF;
        do_cycle(32'h8000_0000, 1'b1, 1'b0);
        do_cycle(32'h8000_0000, 1'b1, 1'b0);
        check("r31_gnt",  obs_gnt,  32'h8000_0000);
        check("r31_data", obs_data, 32'hDEAD_BEEF);
        go_idle();
        do_cycle(32'h8000_0001, 1'b0, 1'b1);
        do_cycle(32'h8000_0001, 1'b1, 1'b1);
        check("wrap_gnt", obs_gnt, 32'h0000_0001);
        go_idle();

        // Requester 5 stalled by ready low, then accepted.
        for (int i = 0; i < 5; i++) do_cycle(32'h0000_0020, 1'b0, 1'b1);
        do_cycle(32'h0000_0020, 1'b1, 1'b1);
        check("r5_gnt", obs_gnt, 32'h0000_0020);
        go_idle();

        // Requester 3 aborts; 3 and 4 then compete and 3 must win.
        do_cycle(32'h0000_0008, 1'b0, 1'b1);
        do_cycle(32'h0000_0008, 1'b0, 1'b1);
        do_cycle(32'h0000_0000, 1'b0, 1'b1);
        do_cycle(32'h0000_0018, 1'b0, 1'b1);
        do_cycle(32'h0000_0018, 1'b1, 1'b1);
        check("abort_gnt", obs_gnt, 32'h0000_0008);
        go_idle();

        // Asynchronous reset between edges while serving.
        do_cycle(32'h0000_0400, 1'b0, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, bus.valid_o}, 32'd0);
        check("arst_busy",  {31'd0, bus.busy_o},  32'd0);
        check("arst_gnt",   bus.gnt_o,  32'd0);
        check("arst_sel",   {27'd0, bus.sel_o}, 32'd0);
        model_reset();
        bus.req_i = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_step();
        do_cycle(32'hFFFF_FFFF, 1'b0, 1'b1);
        do_cycle(32'hFFFF_FFFF, 1'b1, 1'b1);
        ptr_probe = obs_gnt;
        check("arst_resume", ptr_probe, 32'h0000_0001);

        // Randomized traffic with requests that persist over several cycles.
        cur_req = $urandom;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) begin
                case ($urandom_range(3))
                    0: cur_req = 32'd0;
                    1: cur_req = $urandom;
                    2: cur_req = 32'd1 << $urandom_range(31);
                    default: cur_req = $urandom & $urandom & $urandom;
                endcase
            end
            do_cycle(cur_req, 1'($urandom_range(2) != 0), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard time limit so a stuck run still reaches a verdict.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
